// File: rtl/sc_mmio_unit.sv
// Memory-mapped board I/O block: switches, debounced keys, LEDs, hex display, timer, irq.
// Ports: clock/resetn, io_sel/io_addr/io_we/io_wdata/io_rdata CPU bus, sw, key, led, hex, irq.
module sc_mmio_unit #(
    parameter int HEX_DIGITS      = 6,
    parameter int SW_WIDTH        = 10,
    parameter int LED_WIDTH       = 10,
    parameter int KEY_WIDTH       = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    io_sel,
    input  logic [3:0]              io_addr,
    input  logic                    io_we,
    input  logic [31:0]             io_wdata,
    output logic [31:0]             io_rdata,
    input  logic [SW_WIDTH-1:0]     sw,
    input  logic [KEY_WIDTH-1:0]    key,
    output logic [LED_WIDTH-1:0]    led,
    output logic [7*HEX_DIGITS-1:0] hex,
    output logic                    irq
);

    localparam int HW = 4 * HEX_DIGITS;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0]   sw_s1_q, sw_s2_q;
    logic [KEY_WIDTH-1:0]  key_s1_q, key_s2_q;
    logic [DW-1:0]         db_cnt_q [KEY_WIDTH];
    logic [DW-1:0]         db_cnt_d [KEY_WIDTH];
    logic [KEY_WIDTH-1:0]  key_lvl_q, key_lvl_d;
    logic [KEY_WIDTH-1:0]  key_edge_q, key_edge_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;
    logic [HW-1:0]         hex_val_q, hex_val_d;
    logic [HEX_DIGITS-1:0] hex_blank_q, hex_blank_d;
    logic [31:0]           tmr_cnt_q, tmr_cnt_d;
    logic [31:0]           tmr_cmp_q, tmr_cmp_d;
    logic                  tmr_en_q, tmr_en_d;
    logic                  tmr_flag_q, tmr_flag_d;
    logic [KEY_WIDTH:0]    irq_en_q, irq_en_d;
    logic                  irq_q, irq_d;

    logic                  wr;
    logic [KEY_WIDTH-1:0]  key_pressed;
    logic [KEY_WIDTH-1:0]  edge_clr;
    logic                  tmr_match;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        wr          = io_sel & io_we;
        key_pressed = ~key_s2_q;

        // Counter only runs while the synchronized level disagrees with
        // the accepted one; any agreement restarts the qualification.
        key_lvl_d = key_lvl_q;
        for (int i = 0; i < KEY_WIDTH; i++) begin
            db_cnt_d[i] = '0;
            if (key_pressed[i] != key_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    key_lvl_d[i] = key_pressed[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end

        edge_clr = '0;
        if (wr && io_addr == 4'd2) begin
            edge_clr = io_wdata[KEY_WIDTH-1:0];
        end
        // Set term is ORed last so a new press survives a same-cycle clear.
        key_edge_d = (key_edge_q & ~edge_clr) | (key_lvl_d & ~key_lvl_q);

        tmr_match = tmr_en_q && (tmr_cnt_q == tmr_cmp_q);
        tmr_cnt_d = tmr_cnt_q;
        if (wr && io_addr == 4'd8 && io_wdata[2]) begin
            tmr_cnt_d = '0;
        end else if (tmr_en_q) begin
            tmr_cnt_d = tmr_match ? 32'd0 : tmr_cnt_q + 32'd1;
        end
        tmr_flag_d = tmr_match |
                     (tmr_flag_q & ~(wr && io_addr == 4'd8 && io_wdata[1]));

        led_d       = led_q;
        hex_val_d   = hex_val_q;
        hex_blank_d = hex_blank_q;
        tmr_cmp_d   = tmr_cmp_q;
        tmr_en_d    = tmr_en_q;
        irq_en_d    = irq_en_q;
        if (wr) begin
            case (io_addr)
                4'd3: led_d       = io_wdata[LED_WIDTH-1:0];
                4'd4: hex_val_d   = io_wdata[HW-1:0];
                4'd5: hex_blank_d = io_wdata[HEX_DIGITS-1:0];
                4'd7: tmr_cmp_d   = io_wdata;
                4'd8: tmr_en_d    = io_wdata[0];
                4'd9: irq_en_d    = io_wdata[KEY_WIDTH:0];
                default: ;
            endcase
        end

        irq_d = |({key_edge_q, tmr_flag_q} & irq_en_q);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            for (int i = 0; i < KEY_WIDTH; i++) begin
                db_cnt_q[i] <= '0;
            end
            key_lvl_q   <= '0;
            key_edge_q  <= '0;
            led_q       <= '0;
            hex_val_q   <= '0;
            hex_blank_q <= '0;
            tmr_cnt_q   <= '0;
            tmr_cmp_q   <= '0;
            tmr_en_q    <= 1'b0;
            tmr_flag_q  <= 1'b0;
            irq_en_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            sw_s1_q     <= sw;
            sw_s2_q     <= sw_s1_q;
            key_s1_q    <= key;
            key_s2_q    <= key_s1_q;
            for (int i = 0; i < KEY_WIDTH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            key_lvl_q   <= key_lvl_d;
            key_edge_q  <= key_edge_d;
            led_q       <= led_d;
            hex_val_q   <= hex_val_d;
            hex_blank_q <= hex_blank_d;
            tmr_cnt_q   <= tmr_cnt_d;
            tmr_cmp_q   <= tmr_cmp_d;
            tmr_en_q    <= tmr_en_d;
            tmr_flag_q  <= tmr_flag_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        case (io_addr)
            4'd0:    io_rdata = 32'(sw_s2_q);
            4'd1:    io_rdata = 32'(key_lvl_q);
            4'd2:    io_rdata = 32'(key_edge_q);
            4'd3:    io_rdata = 32'(led_q);
            4'd4:    io_rdata = 32'(hex_val_q);
            4'd5:    io_rdata = 32'(hex_blank_q);
            4'd6:    io_rdata = tmr_cnt_q;
            4'd7:    io_rdata = tmr_cmp_q;
            4'd8:    io_rdata = {30'd0, tmr_flag_q, tmr_en_q};
            4'd9:    io_rdata = 32'(irq_en_q);
            default: io_rdata = 32'd0;
        endcase
    end

    // A zeroed HEX_VAL would show '0' glyphs, so reset blanks explicitly.
    always_comb begin
        for (int i = 0; i < HEX_DIGITS; i++) begin
            if (!resetn || hex_blank_q[i]) begin
                hex[7*i +: 7] = 7'h7F;
            end else begin
                hex[7*i +: 7] = seg7(hex_val_q[4*i +: 4]);
            end
        end
    end

    assign led = led_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_sc_mmio_unit.sv
// Self-checking bench for sc_mmio_unit: lockstep reference model
// plus directed scenarios and randomized bus/key/switch traffic.
module tb_sc_mmio_unit;

    localparam int HD  = 6;
    localparam int SWW = 10;
    localparam int LW  = 10;
    localparam int KW  = 3;
    localparam int DEB = 16;
    localparam int HW  = 4 * HD;

    logic            clock = 1'b0;
    logic            resetn = 1'b1;
    logic            io_sel = 1'b0;
    logic [3:0]      io_addr = 4'd0;
    logic            io_we = 1'b0;
    logic [31:0]     io_wdata = 32'd0;
    logic [31:0]     io_rdata;
    logic [SWW-1:0]  sw = '0;
    logic [KW-1:0]   key = '1;
    logic [LW-1:0]   led;
    logic [7*HD-1:0] hex;
    logic            irq;

    sc_mmio_unit #(
        .HEX_DIGITS(HD), .SW_WIDTH(SWW), .LED_WIDTH(LW),
        .KEY_WIDTH(KW), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock), .resetn(resetn), .io_sel(io_sel),
        .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .sw(sw), .key(key), .led(led),
        .hex(hex), .irq(irq)
    );

    always #5 clock = ~clock;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [6:0]     GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                   7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03,
                                   7'h46, 7'h21, 7'h06, 7'h0E};
    logic [SWW-1:0] m_sw1, m_sw2;
    logic [KW-1:0]  m_k1, m_k2, m_stab, m_edge;
    int             m_run [KW];
    logic [LW-1:0]  m_led;
    logic [HW-1:0]  m_hval;
    logic [HD-1:0]  m_blank;
    logic [31:0]    m_tcnt, m_tcmp;
    logic           m_en, m_flag, m_irq;
    logic [KW:0]    m_irqen;

    task automatic model_reset();
        m_sw1 = '0; m_sw2 = '0; m_k1 = '0; m_k2 = '0;
        m_stab = '0; m_edge = '0;
        for (int i = 0; i < KW; i++) m_run[i] = 0;
        m_led = '0; m_hval = '0; m_blank = '0;
        m_tcnt = 0; m_tcmp = 0; m_en = 0; m_flag = 0;
        m_irqen = '0; m_irq = 0;
    endtask

    task automatic model_step();
        logic          w;
        logic [3:0]    a;
        logic [31:0]   d;
        logic [KW-1:0] nstab, pressed, clr;
        logic          match;
        if (!resetn) begin
            model_reset();
            return;
        end
        w = io_sel && io_we;
        a = io_addr;
        d = io_wdata;
        m_irq = |({m_edge, m_flag} & m_irqen);
        // A key level is accepted after DEB consecutive differing samples.
        pressed = ~m_k2;
        nstab = m_stab;
        for (int i = 0; i < KW; i++) begin
            if (pressed[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    nstab[i] = pressed[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        clr = (w && a == 4'd2) ? d[KW-1:0] : '0;
        m_edge = (m_edge & ~clr) | (nstab & ~m_stab);
        m_stab = nstab;
        match = m_en && (m_tcnt == m_tcmp);
        if (w && a == 4'd8 && d[2]) m_tcnt = 0;
        else if (m_en) m_tcnt = match ? 0 : m_tcnt + 1;
        m_flag = match || (m_flag && !(w && a == 4'd8 && d[1]));
        if (w) begin
            case (a)
                4'd3: m_led = d[LW-1:0];
                4'd4: m_hval = d[HW-1:0];
                4'd5: m_blank = d[HD-1:0];
                4'd7: m_tcmp = d;
                4'd8: m_en = d[0];
                4'd9: m_irqen = d[KW:0];
                default: ;
            endcase
        end
        m_sw2 = m_sw1; m_sw1 = sw;
        m_k2 = m_k1; m_k1 = key;
    endtask

    function automatic logic [31:0] exp_rdata(input logic [3:0] a);
        case (a)
            4'd0: return 32'(m_sw2);
            4'd1: return 32'(m_stab);
            4'd2: return 32'(m_edge);
            4'd3: return 32'(m_led);
            4'd4: return 32'(m_hval);
            4'd5: return 32'(m_blank);
            4'd6: return m_tcnt;
            4'd7: return m_tcmp;
            4'd8: return {30'd0, m_flag, m_en};
            4'd9: return 32'(m_irqen);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [7*HD-1:0] exp_hex();
        logic [7*HD-1:0] h;
        for (int i = 0; i < HD; i++) begin
            if (!resetn || m_blank[i]) h[7*i +: 7] = 7'h7F;
            else h[7*i +: 7] = GLYPH[m_hval[4*i +: 4]];
        end
        return h;
    endfunction

    task automatic check_all();
        chk("led", 64'(led), 64'(m_led));
        chk("hex", 64'(hex), 64'(exp_hex()));
        chk("irq", 64'(irq), 64'(m_irq));
        chk("rdata", 64'(io_rdata), 64'(exp_rdata(io_addr)));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        io_sel = 1'b1; io_we = 1'b1; io_addr = a; io_wdata = d;
        tick();
        io_sel = 1'b0; io_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        io_addr = a;
        #1;
        v = io_rdata;
    endtask

    task automatic chk_reset_state(input string tag);
        logic [31:0] v;
        chk({tag, "_led"}, 64'(led), 64'd0);
        chk({tag, "_hex"}, 64'(hex), 64'({HD{7'h7F}}));
        chk({tag, "_irq"}, 64'(irq), 64'd0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), v);
            chk({tag, "_rd"}, 64'(v), 64'd0);
        end
    endtask

    logic [31:0] v;
    int          n;
    int          seq [5] = '{1, 2, 3, 4, 0};

    initial begin
        model_reset();
        #1 resetn = 1'b0;
        @(negedge clock);
        chk_reset_state("rst");
        tick();
        resetn = 1'b1;
        ticks(3);

        // LED and hex display
        wr(4'd3, 32'h2A5);
        wr(4'd4, 32'h00C0FFEE);
        wr(4'd5, 32'h20);
        chk("led_val", 64'(led), 64'h2A5);
        chk("dig0", 64'(hex[0 +: 7]), 64'h06);
        chk("dig1", 64'(hex[7 +: 7]), 64'h06);
        chk("dig2", 64'(hex[14 +: 7]), 64'h0E);
        chk("dig3", 64'(hex[21 +: 7]), 64'h0E);
        chk("dig4_zero", 64'(hex[28 +: 7]), 64'h40);
        chk("dig5_blank", 64'(hex[35 +: 7]), 64'h7F);
        wr(4'd5, 32'h30);
        chk("dig4_blank", 64'(hex[28 +: 7]), 64'h7F);
        rd(4'd4, v);
        chk("hexval_rd", 64'(v), 64'h00C0FFEE);

        // Key debounce with short glitches
        io_addr = 4'd1;
        for (int g = 0; g < 3; g++) begin
            key[1] = 1'b0; ticks(3);
            key[1] = 1'b1; ticks(3);
        end
        ticks(4);
        chk("glitch_lvl", 64'(io_rdata), 64'd0);
        key[1] = 1'b0;
        n = 0;
        while (n < 60) begin
            tick();
            n++;
            if (io_rdata[1]) break;
        end
        chk("deb_latency", 64'(n), 64'(DEB + 2));
        ticks(20 - n);
        rd(4'd2, v);
        chk("key_edge", 64'(v), 64'h2);
        wr(4'd2, 32'h2);
        rd(4'd2, v);
        chk("key_edge_w1c", 64'(v), 64'h0);
        key[1] = 1'b1;
        ticks(25);
        rd(4'd1, v);
        chk("key_release", 64'(v), 64'h0);
        rd(4'd2, v);
        chk("no_release_edge", 64'(v), 64'h0);

        // Timer match and irq
        wr(4'd9, 32'h1);
        wr(4'd7, 32'd4);
        wr(4'd8, 32'h1);
        rd(4'd6, v);
        chk("tmr_start", 64'(v), 64'd0);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                rd(4'd8, v);
                chk("flag_before", 64'(v), 64'h1);
                io_addr = 4'd6;
            end
            tick();
            chk("tmr_seq", 64'(io_rdata), 64'(seq[k]));
        end
        rd(4'd8, v);
        chk("flag_set", 64'(v), 64'h3);
        chk("irq_lag", 64'(irq), 64'd0);
        tick();
        chk("irq_rise", 64'(irq), 64'd1);
        ticks(3);
        rd(4'd6, v);
        chk("tmr_at4", 64'(v), 64'd4);
        wr(4'd8, 32'h3);
        rd(4'd8, v);
        chk("set_wins", 64'(v), 64'h3);
        wr(4'd8, 32'h3);
        rd(4'd8, v);
        chk("flag_w1c", 64'(v), 64'h1);
        tick();
        chk("irq_fall", 64'(irq), 64'd0);

        // Compare written below the running count
        wr(4'd7, 32'd1000);
        wr(4'd8, 32'h5);
        io_addr = 4'd6;
        n = 0;
        while (io_rdata != 32'd100 && n < 300) begin
            tick();
            n++;
        end
        chk("reach100", 64'(io_rdata), 64'd100);
        wr(4'd7, 32'd10);
        ticks(300);
        rd(4'd6, v);
        chk("no_wrap_match", 64'(v), 64'd401);
        rd(4'd8, v);
        chk("no_flag", 64'(v), 64'h1);

        // Compare of zero
        wr(4'd8, 32'h4);
        wr(4'd7, 32'd0);
        wr(4'd8, 32'h1);
        ticks(5);
        rd(4'd6, v);
        chk("cmp0_cnt", 64'(v), 64'd0);
        rd(4'd8, v);
        chk("cmp0_flag", 64'(v), 64'h3);
        wr(4'd8, 32'h3);
        rd(4'd8, v);
        chk("cmp0_reset", 64'(v), 64'h3);
        wr(4'd8, 32'h2);
        wr(4'd8, 32'h2);
        rd(4'd8, v);
        chk("tmr_off", 64'(v), 64'h0);
        wr(4'd9, 32'h0);

        // Reset mid-debounce and mid-count
        wr(4'd3, 32'h155);
        wr(4'd7, 32'd50);
        wr(4'd8, 32'h5);
        ticks(2);
        key[0] = 1'b0;
        ticks(5);
        rd(4'd6, v);
        chk("tmr_at7", 64'(v), 64'd7);
        resetn = 1'b0;
        key = '1;
        model_reset();
        #1;
        chk_reset_state("midrst");
        ticks(2);
        resetn = 1'b1;
        ticks(40);
        rd(4'd2, v);
        chk("post_rst_edge", 64'(v), 64'h0);
        rd(4'd8, v);
        chk("post_rst_tmr", 64'(v), 64'h0);
        rd(4'd6, v);
        chk("post_rst_cnt", 64'(v), 64'h0);

        // Random traffic against the model
        wr(4'd9, 32'hF);
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) sw = SWW'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                n = $urandom_range(0, KW - 1);
                key[n] = ~key[n];
            end
            io_addr = 4'($urandom_range(0, 15));
            io_sel = ($urandom_range(0, 3) != 0);
            io_we = ($urandom_range(0, 3) == 0);
            case (io_addr)
                4'd7: io_wdata = $urandom_range(0, 30);
                4'd8: io_wdata = $urandom_range(0, 7);
                default: io_wdata = $urandom;
            endcase
            tick();
        end
        io_sel = 1'b0;
        io_we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
